// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2,
        ST_PARITY = 2'd3
    } state_t;

    // Sized so cnt can hold n without wrapping after the final beat.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Beat counter for the serializer: synchronous clear, enable, terminal count at N-1.
module bit_counter
    import piso_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with ready/load capture and shift_en paced serial output.
// Optional even-parity trailer bit enabled by defining PISO_SER_PARITY_EN.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int n         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] I,
    input  logic         load,
    output logic         ready,
    input  logic         shift_en,
    output logic         sout,
    output logic         svalid,
    output logic         busy,
    output logic         done
);

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] shreg;
    logic         accept;
    logic         beat;
    logic         tc;

    assign accept = (state == ST_IDLE) && load;
    assign beat   = (state == ST_SHIFT) && shift_en;

    bit_counter #(.N(n)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (beat),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift toward the output end with zero fill so vacated bits never leak out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= I;
        end else if (beat) begin
            shreg <= MSB_FIRST ? {shreg[n-2:0], 1'b0} : {1'b0, shreg[n-1:1]};
        end
    end

`ifdef PISO_SER_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^I;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
`ifdef PISO_SER_PARITY_EN
                if (shift_en && tc) state_nxt = ST_PARITY;
`else
                if (shift_en && tc) state_nxt = ST_DONE;
`endif
            end
            ST_PARITY: begin
`ifdef PISO_SER_PARITY_EN
                if (shift_en) state_nxt = ST_DONE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        svalid = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        sout   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_SHIFT: begin
                svalid = 1'b1;
                busy   = 1'b1;
                sout   = MSB_FIRST ? shreg[n-1] : shreg[0];
            end
            ST_PARITY: begin
`ifdef PISO_SER_PARITY_EN
                svalid = 1'b1;
                busy   = 1'b1;
                sout   = par;
`endif
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer (n=4): MSB-first and LSB-first instances against a queue-based model.
module tb_piso_serializer;

`ifdef PISO_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] I;
    logic         load;
    logic         shift_en;
    logic         ready_m, sout_m, svalid_m, busy_m, done_m;
    logic         ready_l, sout_l, svalid_l, busy_l, done_l;

    always #5 clk = ~clk;

    piso_serializer #(.n(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .I(I), .load(load), .ready(ready_m),
        .shift_en(shift_en), .sout(sout_m), .svalid(svalid_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.n(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .I(I), .load(load), .ready(ready_l),
        .shift_en(shift_en), .sout(sout_l), .svalid(svalid_l), .busy(busy_l), .done(done_l)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 sending (queue holds bits still to go out), 2 done.
    int ph = 0;
    bit q_m[$];
    bit q_l[$];

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            ph = 0;
            q_m.delete();
            q_l.delete();
        end else begin
            case (ph)
                0: if (load) begin
                    q_m.delete();
                    q_l.delete();
                    for (int b = 0; b < N; b++) begin
                        q_m.push_back(I[N-1-b]);
                        q_l.push_back(I[b]);
                    end
                    if (PAR) begin
                        q_m.push_back(^I);
                        q_l.push_back(^I);
                    end
                    ph = 1;
                end
                1: if (shift_en) begin
                    void'(q_m.pop_front());
                    void'(q_l.pop_front());
                    if (q_m.size() == 0) ph = 2;
                end
                default: ph = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            logic [4:0] exp_m, exp_l;
            exp_m = {ph == 0, ph == 1, ph != 0, ph == 2, (ph == 1) ? q_m[0] : 1'b0};
            exp_l = {ph == 0, ph == 1, ph != 0, ph == 2, (ph == 1) ? q_l[0] : 1'b0};
            chk("cycle_msb", {11'd0, ready_m, svalid_m, busy_m, done_m, sout_m}, {11'd0, exp_m});
            chk("cycle_lsb", {11'd0, ready_l, svalid_l, busy_l, done_l, sout_l}, {11'd0, exp_l});
        end
    end

    // Called just after a negedge in IDLE; returns accepted bits of both streams and done cycle.
    task automatic send(input logic [3:0] w, input int stall_at, input int stall_len, input bit poke,
                        output logic [7:0] s_m, output logic [7:0] s_l, output int nb, output int dcyc);
        s_m  = '0;
        s_l  = '0;
        nb   = 0;
        dcyc = -1;
        I = w; load = 1'b1; shift_en = 1'b1;
        @(negedge clk);
        load = 1'b0;
        I = 4'($urandom);
        for (int c = 1; c <= 40; c++) begin
            shift_en = !(c > stall_at && c <= stall_at + stall_len);
            load = 1'b0;
            if (poke && (c == 2 || done_m)) begin
                load = 1'b1;
                I = 4'b0110;
            end
            if (svalid_m && shift_en) begin
                s_m = {s_m[6:0], sout_m};
                s_l = {s_l[6:0], sout_l};
                nb++;
            end
            if (done_m) begin
                dcyc = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        load = 1'b0;
        shift_en = 1'b0;
    endtask

    logic [7:0] s_m, s_l;
    int         nb, dcyc;
    bit         done_seen;

    initial begin
        rst_n = 1'b0; load = 1'b0; shift_en = 1'b0; I = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("reset_outputs", {6'd0, ready_m, svalid_m, busy_m, done_m, sout_m,
                              ready_l, svalid_l, busy_l, done_l, sout_l}, 16'b0000_0010_0001_0000);

        send(4'b1011, 99, 0, 1'b0, s_m, s_l, nb, dcyc);
        chk("b1011_msb_bits", {8'd0, s_m}, PAR ? 16'b10111 : 16'b1011);
        chk("b1011_lsb_bits", {8'd0, s_l}, PAR ? 16'b11011 : 16'b1101);
        chk("b1011_nbits", 16'(nb), PAR ? 16'd5 : 16'd4);
        chk("b1011_done_cycle", 16'(dcyc), PAR ? 16'd6 : 16'd5);
        chk("b1011_ready_after", {15'd0, ready_m}, 16'd1);

        send(4'b1100, 2, 3, 1'b0, s_m, s_l, nb, dcyc);
        chk("stall_msb_bits", {8'd0, s_m}, PAR ? 16'b11000 : 16'b1100);
        chk("stall_lsb_bits", {8'd0, s_l}, PAR ? 16'b00110 : 16'b0011);
        chk("stall_done_cycle", 16'(dcyc), PAR ? 16'd9 : 16'd8);

        send(4'b1011, 99, 0, 1'b1, s_m, s_l, nb, dcyc);
        chk("poke_msb_bits", {8'd0, s_m}, PAR ? 16'b10111 : 16'b1011);
        chk("poke_done_cycle", 16'(dcyc), PAR ? 16'd6 : 16'd5);
        chk("poke_ready_after", {15'd0, ready_m}, 16'd1);

        send(4'b0110, 99, 0, 1'b0, s_m, s_l, nb, dcyc);
        chk("b0110_msb_bits", {8'd0, s_m}, PAR ? 16'b01100 : 16'b0110);
        chk("b0110_lsb_bits", {8'd0, s_l}, PAR ? 16'b01100 : 16'b0110);

        // Reset in the middle of a word: nothing of it may surface afterwards.
        I = 4'b1111; load = 1'b1; shift_en = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_outputs", {6'd0, ready_m, svalid_m, busy_m, done_m, sout_m,
                                 ready_l, svalid_l, busy_l, done_l, sout_l}, 16'b0000_0010_0001_0000);
        done_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_m || done_l) done_seen = 1'b1;
        end
        chk("midreset_no_done", {15'd0, done_seen}, 16'd0);

        repeat (400) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 60) != 0);
            load     = ($urandom_range(0, 3) == 0);
            shift_en = ($urandom_range(0, 3) != 0);
            I        = 4'($urandom);
        end
        rst_n = 1'b1; load = 1'b0; shift_en = 1'b1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
